tree_filler_stage: RTL and testbench
====================================

// Module: tree_filler_stage
// PURPOSE
//  Leaf-side feeder directly upstream of SORTER_STAGE_TREE. Buffers one batch of
//  2^P_LOG records per way (written by the external loader), queues way-index
//  requests issued by the tree's leaf stage, and returns one record per request
//  on dot/doten/dot_idx. Per-way empty flags tell the loader which way to refill.
// PARAMETERS
//  W_LOG   7   log2(number of ways / tree leaves)
//  P_LOG   3   log2(records per batch per way)
//  Q_SIZE  2   log2(request queue depth)
//  DATW    64  record width (bits)
//  KEYW    32  key width, key = record[KEYW-1:0] (carried, not inspected)
// PORTS
//  CLK          in   1              clock, all logic on rising edge
//  RST          in   1              synchronous active-low reset (RST==0 resets)
//  din          in   DATW<<P_LOG    batch; record j = din[DATW*(j+1)-1:DATW*j]
//  dinen        in   1              batch write strobe
//  din_idx      in   W_LOG          destination way of batch
//  i_request    in   W_LOG          way requested by tree leaf stage
//  i_request_valid in 1             request strobe
//  queue_full   out  1              request queue holds 2^Q_SIZE entries
//  dot          out  DATW           returned record
//  doten        out  1              dot valid (1-cycle pulse per record)
//  dot_idx      out  W_LOG          way the record came from
//  emp          out  1<<W_LOG       emp[i]=1: way i holds no unread records
//  err          out  1              sticky protocol-violation flag
// BEHAVIOUR
//  Reset: doten=0, dot=0, dot_idx=0, queue_full=0, err=0, emp=all 1s, queue
//   empty, all per-way counts 0, FSM=IDLE. Reset mid-operation discards queued
//   requests, buffered records and any in-flight read; no doten after release.
//  Storage: sync RAM, 2^(W_LOG+P_LOG) x DATW, addr {way, rdptr}; per way a
//   count cnt[i] (P_LOG+1 bits) of unread records; rdptr = 2^P_LOG - cnt[i].
//  Write: dinen with emp[din_idx]=1 -> all 2^P_LOG records stored, cnt=2^P_LOG,
//   emp[din_idx] falls after that edge. dinen with emp[din_idx]=0 -> ignored,
//   contents unchanged, err<=1.
//  Queue: FIFO of W_LOG-bit indices, depth 2^Q_SIZE. i_request_valid enqueues
//   at the edge; queue_full is registered, =1 exactly when occupancy==2^Q_SIZE.
//   Enqueue while full -> request dropped, err<=1. Enqueue and dequeue in the
//   same cycle when full is legal (occupancy unchanged, no error).
//  FSM (head = queue head index h):
//   IDLE : queue empty -> IDLE. cnt[h]>0 -> issue RAM read {h,rdptr[h]},
//          dequeue, cnt[h]-=1 (emp[h] rises after the edge when cnt hits 0),
//          stay IDLE (one read per cycle sustained). cnt[h]==0 -> STALL.
//   STALL: wait until cnt[h]>0 (i.e. cycle after refill edge), then issue read
//          as in IDLE and return to IDLE. No read to other ways (strict order).
//  Output: read issued at edge E -> dot/dot_idx valid, doten=1 after edge E+1.
//   Latency request->doten = 2 cycles when queue was empty and way non-empty.
//   Within a way, records emitted j=0,1,...,2^P_LOG-1. No output back-pressure:
//   tree reserves space before requesting.
//  Simultaneous refill of way h and STALL on h: write first, read next cycle
//   (no bypass). Refill of way h in same cycle its last record is read: illegal
//   (emp[h] still 0) -> ignored, err<=1.
// TESTING
//  1 Hold RST=0 4 cycles -> emp=all 1s, doten=0, queue_full=0, err=0.
//  2 Write way 3 batch keys 4,132,...,900; request 3 once -> doten 2 cycles
//    later, key 4, dot_idx=3; 7 more back-to-back requests -> keys 132..900 on
//    consecutive cycles; emp[3]=1 after 8th read edge.
//  3 Request way 5 while empty, write way 5 (key 6) 10 cycles later -> no doten
//    before; doten key 6, dot_idx=5 exactly 2 cycles after the write edge.
//  4 4 requests to empty way 9 -> queue_full=1; 5th request -> dropped, err=1;
//    refill way 9 -> exactly 4 records out, queue_full=0.
//  5 Write way 2 while emp[2]=0 -> err=1, later reads return original batch.
//  6 RST=0 for 1 cycle during STALL with 3 queued -> after release queue empty,
//    emp all 1s, no doten for 20 cycles; refill+request works normally.

Source files
------------

// File: rtl/tree_filler_stage.sv
`default_nettype none
// ============================================================================
// Module   : tree_filler_stage
// Purpose  : Leaf-side feeder for the sorter tree. Holds one batch of
//            2^P_LOG records per way, queues way-index requests coming from
//            the tree's leaf stage and returns one record per request, in
//            request order. Per-way empty flags steer the external loader.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK              clock, all logic on the rising edge
//   RST              synchronous active-low reset
//   din              batch, record j = din[DATW*(j+1)-1 : DATW*j]
//   dinen            batch write strobe
//   din_idx          destination way of the batch
//   i_request        way requested by the tree leaf stage
//   i_request_valid  request strobe
//   queue_full       request queue holds 2^Q_SIZE entries
//   dot              returned record
//   doten            dot valid, one-cycle pulse per record
//   dot_idx          way the returned record came from
//   emp              emp[i]=1 : way i holds no unread records
//   err              sticky protocol-violation flag
// ============================================================================
module tree_filler_stage #(
  parameter int W_LOG  = 7,
  parameter int P_LOG  = 3,
  parameter int Q_SIZE = 2,
  parameter int DATW   = 64,
  parameter int KEYW   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [(DATW<<P_LOG)-1:0] din,
  input  logic                     dinen,
  input  logic [W_LOG-1:0]         din_idx,
  input  logic [W_LOG-1:0]         i_request,
  input  logic                     i_request_valid,
  output logic                     queue_full,
  output logic [DATW-1:0]          dot,
  output logic                     doten,
  output logic [W_LOG-1:0]         dot_idx,
  output logic [(1<<W_LOG)-1:0]    emp,
  output logic                     err
);

  localparam int             c_ways    = 1 << W_LOG;
  localparam int             c_recs    = 1 << P_LOG;
  localparam int             c_qslots  = 1 << Q_SIZE;
  localparam logic [P_LOG:0] c_batch   = (P_LOG+1)'(c_recs);
  localparam logic [Q_SIZE:0] c_q_depth = (Q_SIZE+1)'(c_qslots);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Per-way unread-record counters
  logic [P_LOG:0]        r_cnt [c_ways];
  logic [c_ways-1:0]     w_emp;

  // Request queue
  logic [W_LOG-1:0]      r_q [c_qslots];
  logic [Q_SIZE-1:0]     r_q_wp;
  logic [Q_SIZE-1:0]     r_q_rp;
  logic [Q_SIZE:0]       r_q_occ;
  logic                  r_q_full;
  logic [Q_SIZE:0]       w_q_occ_nxt;
  logic                  w_q_empty;
  logic                  w_enq;
  logic                  w_q_err;
  logic [W_LOG-1:0]      w_head;
  logic [P_LOG:0]        w_head_cnt;

  // Read / write control
  logic                  w_rd_en;
  logic [P_LOG-1:0]      w_rd_ptr;
  logic                  w_wr_en;
  logic                  w_wr_err;

  // Read pipeline
  logic                  r_rd_vld;
  logic [W_LOG-1:0]      r_rd_way;
  logic [P_LOG-1:0]      r_rd_ptr;
  logic [c_recs*DATW-1:0] w_bank_flat;
  logic                  r_doten;
  logic [DATW-1:0]       r_dot;
  logic [W_LOG-1:0]      r_dot_idx;
  logic                  r_err;

  // --------------------------------------------------------------------------
  // Empty flags and write acceptance
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < c_ways; i++) begin : g_emp
    assign w_emp[i] = (r_cnt[i] == '0);
  end

  // A way may only be refilled once every record of its previous batch has
  // been read; a refill racing the last read still sees emp=0 and is refused.
  assign w_wr_en  = dinen &&  w_emp[din_idx];
  assign w_wr_err = dinen && !w_emp[din_idx];

  // --------------------------------------------------------------------------
  // Request queue
  // --------------------------------------------------------------------------
  assign w_q_empty  = (r_q_occ == '0);
  assign w_head     = r_q[r_q_rp];
  assign w_head_cnt = r_cnt[w_head];

  // When full, a request is still taken if the head leaves in the same cycle.
  assign w_enq   = i_request_valid && (!r_q_full || w_rd_en);
  assign w_q_err = i_request_valid &&   r_q_full && !w_rd_en;

  assign w_q_occ_nxt = r_q_occ + {{Q_SIZE{1'b0}}, w_enq} - {{Q_SIZE{1'b0}}, w_rd_en};

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_q[r_q_wp] <= i_request;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_q_wp   <= '0;
      r_q_rp   <= '0;
      r_q_occ  <= '0;
      r_q_full <= 1'b0;
    end else begin
      if (w_enq) begin
        r_q_wp <= r_q_wp + 1'b1;
      end
      if (w_rd_en) begin
        r_q_rp <= r_q_rp + 1'b1;
      end
      r_q_occ  <= w_q_occ_nxt;
      r_q_full <= (w_q_occ_nxt == c_q_depth);
    end
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM: strict request order, stalls on an empty head way
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_q_empty) begin
          if (w_head_cnt != '0) begin
            w_rd_en = 1'b1;
          end else begin
            w_state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (!w_q_empty && (w_head_cnt != '0)) begin
          w_rd_en     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Records leave in order 0..2^P_LOG-1, so the slot to read follows from the
  // number of records still unread.
  assign w_rd_ptr = P_LOG'(c_batch - w_head_cnt);

  // --------------------------------------------------------------------------
  // Per-way counters
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < c_ways; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_ways; i++) begin
        if (w_wr_en && (din_idx == W_LOG'(i))) begin
          r_cnt[i] <= c_batch;
        end else if (w_rd_en && (w_head == W_LOG'(i))) begin
          r_cnt[i] <= r_cnt[i] - (P_LOG+1)'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Record storage: one bank per record slot so a whole batch lands in a
  // single cycle; each bank is addressed by way. Only the addressed bank
  // updates its read register, the registered pointer picks it next cycle.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < c_recs; j++) begin : g_bank
    logic [DATW-1:0] r_mem [c_ways];
    logic [DATW-1:0] r_rdata;

    always_ff @(posedge CLK) begin
      if (w_wr_en) begin
        r_mem[din_idx] <= din[DATW*j +: DATW];
      end
      if (w_rd_en && (w_rd_ptr == P_LOG'(j))) begin
        r_rdata <= r_mem[w_head];
      end
    end

    assign w_bank_flat[DATW*j +: DATW] = r_rdata;
  end

  // --------------------------------------------------------------------------
  // Read pipeline and status
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_rd_vld  <= 1'b0;
      r_rd_way  <= '0;
      r_rd_ptr  <= '0;
      r_doten   <= 1'b0;
      r_dot     <= '0;
      r_dot_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_way <= w_head;
        r_rd_ptr <= w_rd_ptr;
      end
      r_doten <= r_rd_vld;
      if (r_rd_vld) begin
        r_dot     <= w_bank_flat[DATW*r_rd_ptr +: DATW];
        r_dot_idx <= r_rd_way;
      end
      r_err <= r_err | w_wr_err | w_q_err;
    end
  end

  // The key sits in the low KEYW bits; it is carried through untouched.
  assign dot        = {r_dot[DATW-1:KEYW], r_dot[KEYW-1:0]};
  assign doten      = r_doten;
  assign dot_idx    = r_dot_idx;
  assign queue_full = r_q_full;
  assign emp        = w_emp;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tree_filler_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_filler_stage
// Purpose  : Self-checking bench for tree_filler_stage (directed vectors).
// Revision : 1.0  initial release
// ============================================================================
module tb_tree_filler_stage;

  localparam int W_LOG  = 7;
  localparam int P_LOG  = 3;
  localparam int Q_SIZE = 2;
  localparam int DATW   = 64;
  localparam int KEYW   = 32;
  localparam int NREC   = 1 << P_LOG;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic [(DATW<<P_LOG)-1:0] din = '0;
  logic                     dinen = 1'b0;
  logic [W_LOG-1:0]         din_idx = '0;
  logic [W_LOG-1:0]         i_request = '0;
  logic                     i_request_valid = 1'b0;
  logic                     queue_full;
  logic [DATW-1:0]          dot;
  logic                     doten;
  logic [W_LOG-1:0]         dot_idx;
  logic [(1<<W_LOG)-1:0]    emp;
  logic                     err;

  int n_chk  = 0;
  int n_fail = 0;

  tree_filler_stage #(
    .W_LOG (W_LOG),
    .P_LOG (P_LOG),
    .Q_SIZE(Q_SIZE),
    .DATW  (DATW),
    .KEYW  (KEYW)
  ) u_dut (
    .CLK            (CLK),
    .RST            (RST),
    .din            (din),
    .dinen          (dinen),
    .din_idx        (din_idx),
    .i_request      (i_request),
    .i_request_valid(i_request_valid),
    .queue_full     (queue_full),
    .dot            (dot),
    .doten          (doten),
    .dot_idx        (dot_idx),
    .emp            (emp),
    .err            (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             req_v;
    logic [W_LOG-1:0] req_way;
    logic             exp_doten;
    logic [DATW-1:0]  exp_dot;
    logic [W_LOG-1:0] exp_idx;
    logic             exp_emp3;
  } vec_t;

  vec_t tbl [10];

  // Record tag: upper half carries way and slot so misrouted data shows up.
  function automatic logic [DATW-1:0] mkrec(input logic [W_LOG-1:0] way,
                                            input int j, input int key);
    logic [15:0] jj;
    logic [31:0] kk;
    jj = j[15:0];
    kk = key[31:0];
    return {8'hA0, 1'b0, way, jj, kk};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [W_LOG-1:0] way, input int base, input int stride);
    for (int j = 0; j < NREC; j++) begin
      din[DATW*j +: DATW] = mkrec(way, j, base + stride*j);
    end
    din_idx = way;
    dinen   = 1'b1;
    step();
    dinen   = 1'b0;
  endtask

  // Steps ncyc cycles; every doten must carry the next in-order record of way.
  task automatic collect(input logic [W_LOG-1:0] way, input int base, input int ncyc,
                         output int got);
    got = 0;
    repeat (ncyc) begin
      step();
      if (doten) begin
        chk("rec_data", 128'(dot), 128'(mkrec(way, got, base + got)));
        chk("rec_idx", 128'(dot_idx), 128'(way));
        got++;
      end
    end
  endtask

  initial begin
    int got;
    int seen;

    // Way 3 batch keys 4,132,...,900; request issued in rows 0..7.
    // Request enqueued at edge k, read at k+1, record visible after k+2.
    for (int k = 0; k < 10; k++) begin
      tbl[k].req_v     = (k < 8);
      tbl[k].req_way   = 7'd3;
      tbl[k].exp_doten = (k >= 2);
      tbl[k].exp_dot   = (k >= 2) ? mkrec(7'd3, k-2, 4 + 128*(k-2)) : '0;
      tbl[k].exp_idx   = 7'd3;
      tbl[k].exp_emp3  = (k >= 8);
    end

    // ---- 1: reset state ----
    repeat (4) step();
    chk("rst_emp", 128'(emp), {128{1'b1}});
    chk("rst_doten", 128'(doten), 128'(0));
    chk("rst_qfull", 128'(queue_full), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_dot", 128'(dot), 128'(0));
    chk("rst_dot_idx", 128'(dot_idx), 128'(0));
    RST = 1'b1;
    step();

    // ---- 2: batch to way 3, eight back-to-back requests ----
    load(7'd3, 4, 128);
    chk("t2_emp3_after_write", 128'(emp[3]), 128'(0));
    for (int k = 0; k < 10; k++) begin
      i_request_valid = tbl[k].req_v;
      i_request       = tbl[k].req_way;
      step();
      chk("t2_doten", 128'(doten), 128'(tbl[k].exp_doten));
      if (tbl[k].exp_doten) begin
        chk("t2_dot", 128'(dot), 128'(tbl[k].exp_dot));
        chk("t2_dot_idx", 128'(dot_idx), 128'(tbl[k].exp_idx));
      end
      chk("t2_emp3", 128'(emp[3]), 128'(tbl[k].exp_emp3));
    end
    i_request_valid = 1'b0;
    step();
    chk("t2_no_extra", 128'(doten), 128'(0));

    // ---- 3: request to empty way 5, refill 10 cycles later ----
    i_request       = 7'd5;
    i_request_valid = 1'b1;
    step();
    i_request_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (doten) seen++;
    end
    chk("t3_no_early_doten", 128'(seen), 128'(0));
    load(7'd5, 6, 1);
    chk("t3_doten_e0", 128'(doten), 128'(0));
    step();
    chk("t3_doten_e1", 128'(doten), 128'(0));
    step();
    chk("t3_doten_e2", 128'(doten), 128'(1));
    chk("t3_dot", 128'(dot), 128'(mkrec(7'd5, 0, 6)));
    chk("t3_dot_idx", 128'(dot_idx), 128'(5));
    step();
    chk("t3_single", 128'(doten), 128'(0));

    // ---- 5: refill of a non-empty way is refused ----
    chk("t5_err_before", 128'(err), 128'(0));
    load(7'd2, 200, 1);
    chk("t5_err_first_write", 128'(err), 128'(0));
    chk("t5_emp2", 128'(emp[2]), 128'(0));
    load(7'd2, 700, 1);
    chk("t5_err_second_write", 128'(err), 128'(1));
    i_request       = 7'd2;
    i_request_valid = 1'b1;
    step();
    step();
    i_request_valid = 1'b0;
    collect(7'd2, 200, 6, got);
    chk("t5_count", 128'(got), 128'(2));

    // Plain reset to clear the sticky error
    RST = 1'b0;
    step();
    RST = 1'b1;
    chk("rst2_err", 128'(err), 128'(0));
    chk("rst2_emp", 128'(emp), {128{1'b1}});

    // ---- 4: queue overflow on empty way 9 ----
    i_request       = 7'd9;
    i_request_valid = 1'b1;
    repeat (4) step();
    chk("t4_qfull", 128'(queue_full), 128'(1));
    chk("t4_err_before", 128'(err), 128'(0));
    step();
    i_request_valid = 1'b0;
    chk("t4_err_drop", 128'(err), 128'(1));
    chk("t4_qfull_hold", 128'(queue_full), 128'(1));
    load(7'd9, 900, 1);
    step();
    chk("t4_qfull_clear", 128'(queue_full), 128'(0));
    collect(7'd9, 900, 12, got);
    chk("t4_count", 128'(got), 128'(4));
    chk("t4_emp9", 128'(emp[9]), 128'(0));

    // ---- 6: reset during STALL with 3 queued ----
    i_request       = 7'd11;
    i_request_valid = 1'b1;
    repeat (3) step();
    i_request_valid = 1'b0;
    step();
    RST = 1'b0;
    step();
    RST = 1'b1;
    chk("t6_qfull", 128'(queue_full), 128'(0));
    chk("t6_emp", 128'(emp), {128{1'b1}});
    chk("t6_err", 128'(err), 128'(0));
    chk("t6_doten", 128'(doten), 128'(0));
    seen = 0;
    repeat (20) begin
      step();
      if (doten) seen++;
    end
    chk("t6_silent", 128'(seen), 128'(0));
    load(7'd11, 1100, 1);
    i_request_valid = 1'b1;
    step();
    i_request_valid = 1'b0;
    collect(7'd11, 1100, 10, got);
    chk("t6_count", 128'(got), 128'(1));

    // Enqueue and dequeue together while full: accepted, no error
    i_request       = 7'd13;
    i_request_valid = 1'b1;
    repeat (4) step();
    i_request_valid = 1'b0;
    chk("t6b_qfull", 128'(queue_full), 128'(1));
    load(7'd13, 1300, 1);
    i_request_valid = 1'b1;
    step();
    i_request_valid = 1'b0;
    chk("t6b_err", 128'(err), 128'(0));
    chk("t6b_qfull_keep", 128'(queue_full), 128'(1));
    collect(7'd13, 1300, 12, got);
    chk("t6b_count", 128'(got), 128'(5));
    chk("t6b_emp13", 128'(emp[13]), 128'(0));
    chk("t6b_err_end", 128'(err), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
